branch_cond_unit: RTL and testbench

BRANCH_COND_UNIT -- requirements
Module: branch_cond_unit

---
 rtl/branch_cond_unit_pkg.sv | 20 ++
 rtl/branch_cond_unit_cond_eval.sv | 33 +++
 rtl/branch_cond_unit.sv | 109 ++++++++++
 tb/tb_branch_cond_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_cond_unit_pkg.sv
// Shared definitions for the branch condition unit: condition encodings and FSM states.
package branch_cond_unit_pkg;

    // Condition select encodings (IR bits)
    localparam logic [2:0] COND_EQ    = 3'b000;  // bus == 0
    localparam logic [2:0] COND_NE    = 3'b001;  // bus != 0
    localparam logic [2:0] COND_GE    = 3'b010;  // bus >= 0
    localparam logic [2:0] COND_LT    = 3'b011;  // bus <  0
    localparam logic [2:0] COND_GT    = 3'b100;  // bus >  0
    localparam logic [2:0] COND_LE    = 3'b101;  // bus <= 0
    localparam logic [2:0] COND_ALWAYS = 3'b110;
    localparam logic [2:0] COND_NEVER = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EVAL = 2'b01,
        HOLD = 2'b10
    } state_e;

endpackage

// File: rtl/branch_cond_unit_cond_eval.sv
// Combinational branch decision from a signed operand and a condition select.
module cond_eval
    import branch_cond_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] operand,
    input  logic [2:0]        cond,
    output logic              decision
);

    logic is_neg;
    logic is_zero;

    assign is_neg  = operand[DATA_W-1];
    assign is_zero = (operand == '0);

    // Decode the condition into a single taken/not-taken bit
    always_comb begin
        decision = 1'b0;
        unique case (cond)
            COND_EQ:     decision = is_zero;
            COND_NE:     decision = ~is_zero;
            COND_GE:     decision = ~is_neg;
            COND_LT:     decision = is_neg;
            COND_GT:     decision = ~is_neg & ~is_zero;
            COND_LE:     decision = is_neg | is_zero;
            COND_ALWAYS: decision = 1'b1;
            COND_NEVER:  decision = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_cond_unit.sv
// Branch condition unit: captures operand/condition on request, evaluates one cycle later,
// and holds the registered decision until the consumer acknowledges it.
module branch_cond_unit
    import branch_cond_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic [DATA_W-1:0] bus,
    input  logic [2:0]        cond,
    input  logic              con_req,
    output logic              con_ready,
    output logic              con_valid,
    input  logic              con_ack,
    output logic              con_out,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  taken_cnt
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   bus_q, bus_d;
    logic [2:0]          cond_q, cond_d;
    logic                con_out_q, con_out_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                capture;
    logic                taken;
    logic                decision;

    // Decision always works on the captured operands, never the live bus
    cond_eval #(
        .DATA_W (DATA_W)
    ) u_cond_eval (
        .operand  (bus_q),
        .cond     (cond_q),
        .decision (decision)
    );

    // Next-state, handshake and operand capture
    always_comb begin
        state_d   = state_q;
        con_out_d = con_out_q;
        con_ready = 1'b0;
        capture   = 1'b0;
        taken     = 1'b0;
        unique case (state_q)
            IDLE: begin
                con_ready = 1'b1;
                if (con_req) begin
                    capture = 1'b1;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                con_out_d = decision;
                taken     = decision;
                state_d   = HOLD;
            end
            HOLD: begin
                // A new request can only slip in on the acknowledging cycle
                con_ready = con_ack;
                if (con_ack) begin
                    if (con_req) begin
                        capture = 1'b1;
                        state_d = EVAL;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        bus_d  = capture ? bus  : bus_q;
        cond_d = capture ? cond : cond_q;
    end

    // Saturating taken counter; clear wins over a same-edge increment
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (taken && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State, operand and result registers
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q   <= IDLE;
            bus_q     <= '0;
            cond_q    <= '0;
            con_out_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            bus_q     <= bus_d;
            cond_q    <= cond_d;
            con_out_q <= con_out_d;
            cnt_q     <= cnt_d;
        end
    end

    assign con_valid = (state_q == HOLD);
    assign con_out   = con_out_q;
    assign taken_cnt = cnt_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Randomized self-checking bench: a 32-bit/16-bit-counter unit and an 8-bit/2-bit-counter
// unit share all control inputs and are compared against a transaction-level model.
module tb_branch_cond_unit;

    logic        clk = 1'b0;
    logic        clear_n;
    logic        con_req, con_ack, cnt_clr;
    logic [2:0]  cond;
    logic [31:0] bus_a;
    logic [7:0]  bus_b;
    logic        ready_a, valid_a, out_a;
    logic        ready_b, valid_b, out_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: an evaluation in flight, a result on offer, and per-unit results
    bit m_pend;
    bit m_valid;
    bit m_pdec [2];
    bit m_out  [2];
    int m_cnt  [2];
    int cnt_max [2] = '{65535, 3};

    always #5 clk = ~clk;

    branch_cond_unit #(
        .DATA_W (32),
        .CNT_W  (16)
    ) dut_a (
        .clk       (clk),
        .clear_n   (clear_n),
        .bus       (bus_a),
        .cond      (cond),
        .con_req   (con_req),
        .con_ready (ready_a),
        .con_valid (valid_a),
        .con_ack   (con_ack),
        .con_out   (out_a),
        .cnt_clr   (cnt_clr),
        .taken_cnt (cnt_a)
    );

    branch_cond_unit #(
        .DATA_W (8),
        .CNT_W  (2)
    ) dut_b (
        .clk       (clk),
        .clear_n   (clear_n),
        .bus       (bus_b),
        .cond      (cond),
        .con_req   (con_req),
        .con_ready (ready_b),
        .con_valid (valid_b),
        .con_ack   (con_ack),
        .con_out   (out_b),
        .cnt_clr   (cnt_clr),
        .taken_cnt (cnt_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decision on the operand's signed integer value
    function automatic bit ref_dec(input longint v, input logic [2:0] c);
        case (c)
            3'd0:    return v == 0;
            3'd1:    return v != 0;
            3'd2:    return v >= 0;
            3'd3:    return v < 0;
            3'd4:    return v > 0;
            3'd5:    return v <= 0;
            3'd6:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_ready();
        return !m_pend && (!m_valid || con_ack);
    endfunction

    task automatic model_reset();
        m_pend  = 0;
        m_valid = 0;
        for (int i = 0; i < 2; i++) begin
            m_pdec[i] = 0;
            m_out[i]  = 0;
            m_cnt[i]  = 0;
        end
    endtask

    // Advance the model across one rising edge using the inputs present at that edge
    task automatic model_edge();
        bit     rdy;
        longint va, vb;
        rdy = m_ready();
        va  = longint'($signed(bus_a));
        vb  = longint'($signed(bus_b));
        if (m_pend) begin
            m_valid = 1;
            for (int i = 0; i < 2; i++) begin
                m_out[i] = m_pdec[i];
                if (m_pdec[i] && m_cnt[i] < cnt_max[i]) m_cnt[i]++;
            end
        end else if (m_valid && con_ack) begin
            m_valid = 0;
        end
        if (rdy && con_req) begin
            m_pend    = 1;
            m_pdec[0] = ref_dec(va, cond);
            m_pdec[1] = ref_dec(vb, cond);
        end else begin
            m_pend = 0;
        end
        if (cnt_clr) begin
            m_cnt[0] = 0;
            m_cnt[1] = 0;
        end
    endtask

    task automatic check_outputs();
        check("ready_a", 64'(ready_a), 64'(m_ready()));
        check("valid_a", 64'(valid_a), 64'(m_valid));
        check("out_a",   64'(out_a),   64'(m_out[0]));
        check("cnt_a",   64'(cnt_a),   64'(m_cnt[0]));
        check("ready_b", 64'(ready_b), 64'(m_ready()));
        check("valid_b", 64'(valid_b), 64'(m_valid));
        check("out_b",   64'(out_b),   64'(m_out[1]));
        check("cnt_b",   64'(cnt_b),   64'(m_cnt[1]));
    endtask

    // Called at a falling edge with inputs already driven
    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        if (clear_n) model_edge();
        @(negedge clk);
    endtask

    // Reset takes effect at once, held across one rising edge
    task automatic pulse_reset();
        clear_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        clear_n = 1'b1;
    endtask

    initial begin
        clear_n = 1'b1;
        con_req = 0;
        con_ack = 0;
        cnt_clr = 0;
        cond    = 3'd0;
        bus_a   = '0;
        bus_b   = '0;
        #2;
        clear_n = 1'b0;
        model_reset();
        @(negedge clk);
        check_outputs();
        clear_n = 1'b1;

        // Zero test, single-cycle request pulse
        cond = 3'd0; bus_a = 32'd0; bus_b = 8'd0; con_req = 1;
        step();
        con_req = 0;
        step();
        #1;
        check("r036_valid", 64'(valid_a), 64'd1);
        check("r036_out",   64'(out_a),   64'd1);
        check("r036_cnt",   64'(cnt_a),   64'd1);

        // Stall in HOLD with requests pending, then back-to-back accept
        con_ack = 0; con_req = 1;
        for (int i = 0; i < 3; i++) step();
        #1;
        check("r038_ready", 64'(ready_a), 64'd0);
        check("r038_valid", 64'(valid_a), 64'd1);
        con_ack = 1; con_req = 1; cond = 3'd1; bus_a = 32'd0; bus_b = 8'd0;
        step();
        con_ack = 0; con_req = 0;
        step();
        #1;
        check("r038_out", 64'(out_a), 64'd0);
        check("r038_cnt", 64'(cnt_a), 64'd1);

        // Captured operand wins over a later bus change
        con_ack = 1;
        step();
        con_ack = 0; cond = 3'd3; bus_a = -32'sd5; bus_b = -8'sd5; con_req = 1;
        step();
        con_req = 0; bus_a = 32'd5; bus_b = 8'd5;
        step();
        #1;
        check("r037_out_a", 64'(out_a), 64'd1);
        check("r037_out_b", 64'(out_b), 64'd1);

        // Counter saturation on the narrow unit, then clear against a taken edge
        con_ack = 1;
        step();
        pulse_reset();
        cond = 3'd6; con_req = 1; con_ack = 1;
        for (int i = 0; i < 8; i++) step();
        #1;
        check("r039_sat_b", 64'(cnt_b), 64'd3);
        check("r039_cnt_a", 64'(cnt_a), 64'd4);
        step();
        con_req = 0; con_ack = 0; cnt_clr = 1;
        step();
        cnt_clr = 0;
        #1;
        check("r039_clr_b", 64'(cnt_b), 64'd0);
        check("r039_valid", 64'(valid_b), 64'd1);

        // Reset during EVAL aborts the evaluation
        con_ack = 1;
        step();
        con_ack = 0; cond = 3'd4; bus_a = 32'd7; bus_b = 8'd7; con_req = 1;
        step();
        con_req = 0;
        pulse_reset();
        check("r040_out",   64'(out_a),   64'd0);
        check("r040_valid", 64'(valid_a), 64'd0);
        for (int i = 0; i < 3; i++) step();

        // Narrow-width sign boundaries
        cond = 3'd4; bus_a = 32'h80; bus_b = 8'h80; con_req = 1;
        step();
        con_req = 0;
        step();
        #1;
        check("r041_gt_b", 64'(out_b), 64'd0);
        check("r041_gt_a", 64'(out_a), 64'd1);
        con_ack = 1; con_req = 1; cond = 3'd5; bus_b = 8'h00; bus_a = 32'h1;
        step();
        con_ack = 0; con_req = 0;
        step();
        #1;
        check("r041_le_b", 64'(out_b), 64'd1);
        check("r041_le_a", 64'(out_a), 64'd0);
        con_ack = 1; con_req = 1; cond = 3'd7; bus_b = 8'($urandom); bus_a = $urandom;
        step();
        con_ack = 0; con_req = 0;
        step();
        #1;
        check("r041_nv_b", 64'(out_b), 64'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            con_req = 1'($urandom);
            con_ack = 1'($urandom);
            cond    = 3'($urandom);
            cnt_clr = ($urandom_range(0, 31) == 0);
            case ($urandom_range(0, 3))
                0:       bus_a = 32'd0;
                1:       bus_a = 32'($signed($urandom_range(0, 6)) - 3);
                2:       bus_a = 32'h8000_0000;
                default: bus_a = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       bus_b = 8'd0;
                1:       bus_b = 8'($signed($urandom_range(0, 6)) - 3);
                2:       bus_b = 8'h80;
                default: bus_b = 8'($urandom);
            endcase
            if ($urandom_range(0, 99) == 0) pulse_reset();
            else step();
        end
        cnt_clr = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
